adc_trig_averager: RTL and testbench

- Input-side counterpart to the register-to-DAC output path: reads ADC channels InputA/InputB and returns averaged values for the wrapper to drive onto outputs or status.
- Sequence: armed by a control bit, triggered by ExtTrig, then averages 2^Log2N consecutive samples per channel.
- Sits inside CustomWrapper, between the ADC inputs, the Control-register fields and the output mux.

---
 rtl/adc_trig_averager.sv | 134 +++++++++++++
 tb/tb_adc_trig_averager.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_averager.sv
// Armed, externally triggered block averager for two signed ADC channels.
// Averages 2^Log2N consecutive samples per channel starting at the trigger edge.
module adc_trig_averager #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_LOG2N = 10
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic signed [DATA_W-1:0] InputA,
    input  logic signed [DATA_W-1:0] InputB,
    input  logic                     ExtTrig,
    input  logic                     Arm,
    input  logic                     Abort,
    input  logic                     Continuous,
    input  logic [3:0]               Log2N,
    output logic signed [DATA_W-1:0] ResultA,
    output logic signed [DATA_W-1:0] ResultB,
    output logic                     Valid,
    output logic                     Busy,
    output logic                     ArmedFlag
);

    localparam int unsigned ACC_W = DATA_W + MAX_LOG2N;
    localparam int unsigned CNT_W = MAX_LOG2N;
    localparam logic [3:0]  MAX_L = 4'(MAX_LOG2N);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACCUM = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                    arm_q, trig_q;
    logic                    arm_rise, trig_rise;
    logic                    acc_load, acc_add, res_load;
    logic [3:0]              log2n_clamp;
    logic [3:0]              shift_q;
    logic [CNT_W-1:0]        cnt_q, cnt_init;
    logic signed [ACC_W-1:0] acc_a, acc_b;
    logic signed [ACC_W-1:0] sext_a, sext_b;
    logic signed [ACC_W-1:0] avg_a, avg_b;

    assign arm_rise    = Arm & ~arm_q;
    assign trig_rise   = ExtTrig & ~trig_q;
    assign log2n_clamp = (Log2N > MAX_L) ? MAX_L : Log2N;
    assign cnt_init    = ~(CNT_ONES << log2n_clamp);
    assign sext_a      = {{MAX_LOG2N{InputA[DATA_W-1]}}, InputA};
    assign sext_b      = {{MAX_LOG2N{InputB[DATA_W-1]}}, InputB};
    // Arithmetic shift floors toward -inf; accumulator headroom makes truncation exact.
    assign avg_a       = acc_a >>> shift_q;
    assign avg_b       = acc_b >>> shift_q;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; Abort overrides everything, including completion
    always_comb begin
        state_d  = state_q;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        res_load = 1'b0;
        if (Abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_rise) state_d = ARMED;
                end
                ARMED: begin
                    if (trig_rise) begin
                        state_d  = ACCUM;
                        acc_load = 1'b1;
                    end
                end
                ACCUM: begin
                    if (cnt_q == '0) begin
                        res_load = 1'b1;
                        state_d  = Continuous ? ARMED : IDLE;
                    end else begin
                        acc_add = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Edge detect, accumulators, counter and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            arm_q     <= 1'b0;
            trig_q    <= 1'b0;
            acc_a     <= '0;
            acc_b     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            ResultA   <= '0;
            ResultB   <= '0;
            Valid     <= 1'b0;
            Busy      <= 1'b0;
            ArmedFlag <= 1'b0;
        end else begin
            arm_q  <= Arm;
            trig_q <= ExtTrig;
            if (acc_load) begin
                acc_a   <= sext_a;
                acc_b   <= sext_b;
                cnt_q   <= cnt_init;
                shift_q <= log2n_clamp;
            end else if (acc_add) begin
                acc_a <= acc_a + sext_a;
                acc_b <= acc_b + sext_b;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (res_load) begin
                ResultA <= avg_a[DATA_W-1:0];
                ResultB <= avg_b[DATA_W-1:0];
            end
            Valid     <= res_load;
            Busy      <= (state_d != IDLE);
            ArmedFlag <= (state_d == ARMED);
        end
    end

endmodule

// File: tb/tb_adc_trig_averager.sv
// Directed self-checking bench for adc_trig_averager.
module tb_adc_trig_averager;

    logic               Clk = 1'b0;
    logic               Reset;
    logic signed [15:0] InputA, InputB;
    logic               ExtTrig, Arm, Abort, Continuous;
    logic [3:0]         Log2N;
    logic signed [15:0] ResultA, ResultB;
    logic               Valid, Busy, ArmedFlag;

    int n_checks = 0;
    int n_fail   = 0;

    adc_trig_averager #(.DATA_W(16), .MAX_LOG2N(10)) dut (
        .Clk(Clk), .Reset(Reset), .InputA(InputA), .InputB(InputB),
        .ExtTrig(ExtTrig), .Arm(Arm), .Abort(Abort), .Continuous(Continuous),
        .Log2N(Log2N), .ResultA(ResultA), .ResultB(ResultB), .Valid(Valid),
        .Busy(Busy), .ArmedFlag(ArmedFlag)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic arm_pulse();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    // Ticks until Valid is seen; returns limit if it never comes
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            tick();
            cyc++;
            if (Valid) break;
        end
    endtask

    int lat;
    int seen;
    int vals [3] = '{7, -5, 300};

    initial begin
        Reset = 1'b0; InputA = 16'sd1000; InputB = 16'sd0;
        ExtTrig = 1'b0; Arm = 1'b0; Abort = 1'b0; Continuous = 1'b0; Log2N = 4'd2;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        check("rst_resA", ResultA, 0);
        check("rst_valid", Valid, 0);
        check("rst_busy", Busy, 0);

        // Basic N=4 constant input
        arm_pulse();
        check("arm_flag", ArmedFlag, 1);
        check("arm_busy", Busy, 1);
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        check("accum_flag", ArmedFlag, 0);
        check("accum_busy", Busy, 1);
        wait_valid(10, lat);
        check("n4_lat", lat, 4);
        check("n4_resA", ResultA, 1000);
        tick();
        check("n4_pulse", Valid, 0);
        check("n4_idle", Busy, 0);

        // Floor behaviour: 11>>>2 = 2, -11>>>2 = -3
        arm_pulse();
        InputA = 16'sd1; InputB = -16'sd1; ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        InputA = 16'sd2; InputB = -16'sd2; tick();
        InputA = 16'sd3; InputB = -16'sd3; tick();
        InputA = 16'sd5; InputB = -16'sd5; tick();
        InputA = 16'sd0; InputB = 16'sd0;
        tick();
        check("seq_valid", Valid, 1);
        check("seq_resA", ResultA, 2);
        check("seq_resB", ResultB, -3);

        // Full scale at N=1024, then Log2N=15 clamped to 10
        InputA = -16'sd32768; InputB = 16'sd32767;
        for (int k = 0; k < 2; k++) begin
            Log2N = (k == 0) ? 4'd10 : 4'd15;
            arm_pulse();
            ExtTrig = 1'b1;
            tick();
            ExtTrig = 1'b0;
            wait_valid(1100, lat);
            check("fs_lat", lat, 1024);
            check("fs_resA", ResultA, -32768);
            check("fs_resB", ResultB, 32767);
        end

        // Continuous, N=1, trigger every 2 cycles
        Log2N = 4'd0; Continuous = 1'b1;
        arm_pulse();
        for (int k = 0; k < 3; k++) begin
            InputA = 16'(vals[k]); ExtTrig = 1'b1;
            tick();
            check("cont_busy_acc", Busy, 1);
            ExtTrig = 1'b0; InputA = 16'sd0;
            if (k == 2) Continuous = 1'b0;
            tick();
            check("cont_valid", Valid, 1);
            check("cont_resA", ResultA, vals[k]);
            check("cont_busy", Busy, (k == 2) ? 0 : 1);
        end

        // Abort at cycle 2 of N=8; extra triggers in IDLE ignored
        Log2N = 4'd3; InputA = 16'sd999;
        arm_pulse();
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_valid", Valid, 0);
        check("abort_resA", ResultA, 300);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            ExtTrig = k[1];
            tick();
            if (Valid || Busy) seen++;
        end
        ExtTrig = 1'b0;
        check("idle_trig_ignored", seen, 0);

        // Extra trigger edge during ACCUM has no effect
        Log2N = 4'd2; InputA = 16'sd200;
        tick();
        arm_pulse();
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        tick();
        ExtTrig = 1'b1;
        wait_valid(10, lat);
        ExtTrig = 1'b0;
        check("acc_trig_lat", lat, 3);
        check("acc_trig_resA", ResultA, 200);

        // Reset mid-ACCUM clears outputs without a clock edge
        tick();
        Log2N = 4'd3; InputA = 16'sd500;
        arm_pulse();
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        tick();
        #2 Reset = 1'b0;
        #1;
        check("arst_resA", ResultA, 0);
        check("arst_busy", Busy, 0);
        check("arst_valid", Valid, 0);
        tick();
        Reset = 1'b1;
        tick();

        // Simultaneous Arm and trigger in IDLE: ARMED only
        Log2N = 4'd0; InputA = 16'sd77;
        Arm = 1'b1; ExtTrig = 1'b1;
        tick();
        Arm = 1'b0;
        check("simul_armed", ArmedFlag, 1);
        tick();
        check("simul_hold", ArmedFlag, 1);
        ExtTrig = 1'b0;
        tick();
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        check("simul_accum", ArmedFlag, 0);
        wait_valid(5, lat);
        check("simul_lat", lat, 1);
        check("simul_resA", ResultA, 77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
